bnn_uart_link: RTL

//  Parametrised full-duplex UART link between the host and the BNN core; successor to the RX-only controller front end.

---
 rtl/bnn_uart_pkg.sv | 22 ++
 rtl/bnn_sync_fifo.sv | 46 ++++
 rtl/bnn_uart_link.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bnn_uart_pkg.sv
// Shared types and helpers for the BNN host UART link.
// Optional parity support is compiled in with BNN_UART_PARITY_EN.
package bnn_uart_pkg;
  localparam int MAX_BITS = 9;

  typedef enum logic [2:0] {
    R_IDLE, R_START, R_DATA, R_PARITY, R_STOP, R_WAIT
  } rx_state_t;

  typedef enum logic [2:0] {
    T_IDLE, T_LOAD, T_START, T_DATA, T_PARITY, T_STOP
  } tx_state_t;

  // Tick index (from start detection) at which the start bit is re-checked.
  function automatic int mid_tick(input int os);
    return os / 2;
  endfunction

  function automatic logic even_par(input logic [MAX_BITS-1:0] d);
    return ^d;
  endfunction
endpackage

// File: rtl/bnn_sync_fifo.sv
// First-word fall-through synchronous FIFO; a push while full is taken
// only when a pop happens in the same cycle.
module bnn_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp, r_rp;
  logic [AW:0]      r_cnt;
  logic             w_push, w_pop;

  assign empty  = (r_cnt == '0);
  assign full   = (r_cnt == (AW+1)'(DEPTH));
  assign level  = r_cnt;
  assign rdata  = r_mem[r_rp];
  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= wdata;
  end
endmodule

// File: rtl/bnn_uart_link.sv
// Full-duplex host UART link for the BNN core: oversampled RX into a FIFO,
// TX serialiser, RTS/CTS, sticky errors. Define BNN_UART_PARITY_EN for even parity.
module bnn_uart_link
  import bnn_uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int CTS_MARGIN = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          baud_clk,
  input  logic                          uart_rx,
  input  logic                          uart_rts,
  output logic                          uart_tx,
  output logic                          uart_cts,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   rx_level,
  output logic                          rx_overrun,
  output logic                          rx_frame_err,
`ifdef BNN_UART_PARITY_EN
  output logic                          rx_parity_err,
`endif
  input  logic                          err_clr
);
  localparam int CW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS);
  localparam int LW  = $clog2(FIFO_DEPTH) + 1;
  localparam int MID = mid_tick(OVERSAMPLE);

  // ---------------- RX ----------------
  logic [1:0]           r_rx_sync;
  logic                 w_rx;
  rx_state_t            r_rx_st, w_rx_st_n;
  logic [CW-1:0]        r_rx_cnt, w_rx_cnt_n;
  logic [BW-1:0]        r_rx_bit, w_rx_bit_n;
  logic [DATA_BITS-1:0] r_rx_sh, w_rx_sh_n;
  logic                 w_stop_ok, w_stop_bad, w_par_bad, w_push_set;
  logic                 r_push;
  logic [DATA_BITS-1:0] r_push_data;
  logic                 w_full, w_empty, w_pop;
  logic                 r_ovr, r_ferr, r_cts;

  assign w_rx = r_rx_sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rx_sync <= 2'b11;
    else        r_rx_sync <= {r_rx_sync[0], uart_rx};
  end

  always_comb begin
    w_rx_st_n  = r_rx_st;
    w_rx_cnt_n = r_rx_cnt;
    w_rx_bit_n = r_rx_bit;
    w_rx_sh_n  = r_rx_sh;
    w_stop_ok  = 1'b0;
    w_stop_bad = 1'b0;
    w_par_bad  = 1'b0;
    if (baud_clk) begin
      case (r_rx_st)
        R_IDLE: if (!w_rx) begin
          w_rx_st_n  = R_START;
          w_rx_cnt_n = '0;
        end
        R_START: if (r_rx_cnt == CW'(MID-1)) begin
          w_rx_cnt_n = '0;
          w_rx_bit_n = '0;
          w_rx_st_n  = w_rx ? R_IDLE : R_DATA;
        end else w_rx_cnt_n = r_rx_cnt + 1'b1;
        R_DATA: if (r_rx_cnt == CW'(OVERSAMPLE-1)) begin
          w_rx_cnt_n = '0;
          w_rx_sh_n  = {w_rx, r_rx_sh[DATA_BITS-1:1]};
          if (r_rx_bit == BW'(DATA_BITS-1))
`ifdef BNN_UART_PARITY_EN
            w_rx_st_n = R_PARITY;
`else
            w_rx_st_n = R_STOP;
`endif
          else w_rx_bit_n = r_rx_bit + 1'b1;
        end else w_rx_cnt_n = r_rx_cnt + 1'b1;
        R_PARITY: if (r_rx_cnt == CW'(OVERSAMPLE-1)) begin
          w_rx_cnt_n = '0;
          w_par_bad  = (w_rx != even_par(MAX_BITS'(r_rx_sh)));
          w_rx_st_n  = R_STOP;
        end else w_rx_cnt_n = r_rx_cnt + 1'b1;
        R_STOP: if (r_rx_cnt == CW'(OVERSAMPLE-1)) begin
          w_rx_cnt_n = '0;
          w_stop_ok  = w_rx;
          w_stop_bad = !w_rx;
          w_rx_st_n  = w_rx ? R_IDLE : R_WAIT;
        end else w_rx_cnt_n = r_rx_cnt + 1'b1;
        R_WAIT: if (w_rx) w_rx_st_n = R_IDLE;
        default: w_rx_st_n = R_IDLE;
      endcase
    end
  end

`ifdef BNN_UART_PARITY_EN
  logic r_rx_pbad, r_perr;
  assign w_push_set    = w_stop_ok && !r_rx_pbad;
  assign rx_parity_err = r_perr;

  // Parity verdict is held until the stop bit decides whether to push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_pbad <= 1'b0;
      r_perr    <= 1'b0;
    end else begin
      if (r_rx_st == R_IDLE && w_rx_st_n == R_START) r_rx_pbad <= 1'b0;
      else if (w_par_bad)                            r_rx_pbad <= 1'b1;
      r_perr <= w_par_bad | (r_perr & ~err_clr);
    end
  end
`else
  assign w_push_set = w_stop_ok;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_st     <= R_IDLE;
      r_rx_cnt    <= '0;
      r_rx_bit    <= '0;
      r_rx_sh     <= '0;
      r_push      <= 1'b0;
      r_push_data <= '0;
      r_ovr       <= 1'b0;
      r_ferr      <= 1'b0;
      r_cts       <= 1'b0;
    end else begin
      r_rx_st     <= w_rx_st_n;
      r_rx_cnt    <= w_rx_cnt_n;
      r_rx_bit    <= w_rx_bit_n;
      r_rx_sh     <= w_rx_sh_n;
      r_push      <= w_push_set;
      r_push_data <= r_rx_sh;
      r_ovr       <= (r_push && w_full && !w_pop) | (r_ovr & ~err_clr);
      r_ferr      <= w_stop_bad | (r_ferr & ~err_clr);
      r_cts       <= (rx_level < LW'(FIFO_DEPTH-CTS_MARGIN));
    end
  end

  assign w_pop        = rx_ready && !w_empty;
  assign rx_valid     = !w_empty;
  assign rx_overrun   = r_ovr;
  assign rx_frame_err = r_ferr;
  assign uart_cts     = r_cts;

  bnn_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_BITS)) u_rx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (r_push),
    .wdata (r_push_data),
    .pop   (rx_ready),
    .rdata (rx_data),
    .full  (w_full),
    .empty (w_empty),
    .level (rx_level)
  );

  // ---------------- TX ----------------
  tx_state_t            r_tx_st, w_tx_st_n;
  logic [CW-1:0]        r_tx_cnt, w_tx_cnt_n;
  logic [BW-1:0]        r_tx_bit, w_tx_bit_n;
  logic [DATA_BITS-1:0] r_tx_sh, w_tx_sh_n;
  logic                 r_tx_line, w_tx_line_n;
  logic                 r_tx_par, w_tx_par_n;
  logic                 r_tx_ready, w_tx_hs;

  assign w_tx_hs  = tx_valid && r_tx_ready && (r_tx_st == T_IDLE);
  assign tx_ready = r_tx_ready;
  assign uart_tx  = r_tx_line;

  always_comb begin
    w_tx_st_n   = r_tx_st;
    w_tx_cnt_n  = r_tx_cnt;
    w_tx_bit_n  = r_tx_bit;
    w_tx_sh_n   = r_tx_sh;
    w_tx_line_n = r_tx_line;
    w_tx_par_n  = r_tx_par;
    case (r_tx_st)
      T_IDLE: if (w_tx_hs) begin
        w_tx_st_n  = T_LOAD;
        w_tx_sh_n  = tx_data;
        w_tx_par_n = even_par(MAX_BITS'(tx_data));
      end
      T_LOAD: if (baud_clk) begin
        w_tx_st_n   = T_START;
        w_tx_cnt_n  = '0;
        w_tx_line_n = 1'b0;
      end
      T_START: if (baud_clk) begin
        if (r_tx_cnt == CW'(OVERSAMPLE-1)) begin
          w_tx_cnt_n  = '0;
          w_tx_bit_n  = '0;
          w_tx_line_n = r_tx_sh[0];
          w_tx_st_n   = T_DATA;
        end else w_tx_cnt_n = r_tx_cnt + 1'b1;
      end
      T_DATA: if (baud_clk) begin
        if (r_tx_cnt == CW'(OVERSAMPLE-1)) begin
          w_tx_cnt_n = '0;
          if (r_tx_bit == BW'(DATA_BITS-1)) begin
`ifdef BNN_UART_PARITY_EN
            w_tx_line_n = r_tx_par;
            w_tx_st_n   = T_PARITY;
`else
            w_tx_line_n = 1'b1;
            w_tx_st_n   = T_STOP;
`endif
          end else begin
            w_tx_sh_n   = {1'b0, r_tx_sh[DATA_BITS-1:1]};
            w_tx_line_n = r_tx_sh[1];
            w_tx_bit_n  = r_tx_bit + 1'b1;
          end
        end else w_tx_cnt_n = r_tx_cnt + 1'b1;
      end
      T_PARITY: if (baud_clk) begin
        if (r_tx_cnt == CW'(OVERSAMPLE-1)) begin
          w_tx_cnt_n  = '0;
          w_tx_line_n = 1'b1;
          w_tx_st_n   = T_STOP;
        end else w_tx_cnt_n = r_tx_cnt + 1'b1;
      end
      T_STOP: if (baud_clk) begin
        if (r_tx_cnt == CW'(OVERSAMPLE-1)) begin
          w_tx_cnt_n = '0;
          w_tx_st_n  = T_IDLE;
        end else w_tx_cnt_n = r_tx_cnt + 1'b1;
      end
      default: begin
        w_tx_st_n   = T_IDLE;
        w_tx_line_n = 1'b1;
      end
    endcase
  end

  // Ready is registered so it falls the clk after a handshake and tracks RTS with one clk lag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_st    <= T_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_sh    <= '0;
      r_tx_line  <= 1'b1;
      r_tx_par   <= 1'b0;
      r_tx_ready <= 1'b0;
    end else begin
      r_tx_st    <= w_tx_st_n;
      r_tx_cnt   <= w_tx_cnt_n;
      r_tx_bit   <= w_tx_bit_n;
      r_tx_sh    <= w_tx_sh_n;
      r_tx_line  <= w_tx_line_n;
      r_tx_par   <= w_tx_par_n;
      r_tx_ready <= (w_tx_st_n == T_IDLE) && uart_rts;
    end
  end
endmodule
